hd44780_lcd_model: RTL

// - Display-side responder for the 4-bit HD44780 bus: samples e/rs/db, rebuilds bytes from nibbles, executes instructions.
// - Holds a 128-byte DDRAM image and display state so benches and on-chip monitors can check what the panel shows.
// - Sits on the same clk as the controller, attached directly to its e/rs/db outputs.

---
 rtl/hd44780_lcd_model_pkg.sv | 63 ++++++
 rtl/hd44780_ddram.sv | 29 ++
 rtl/hd44780_lcd_model.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/hd44780_lcd_model_pkg.sv
// Shared definitions for the HD44780 display-side model: bus widths,
// instruction opcodes, DDRAM line addresses, FSM state and the ac step helper.
package hd44780_lcd_model_pkg;

  localparam int unsigned BUS_WIDTH = 4;
  localparam int unsigned ADDR_W    = 7;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned DEPTH     = 128;

  // Nibbles recognised while the panel is still in 8-bit boot mode
  localparam logic [BUS_WIDTH-1:0] NIB_BOOT8 = 4'h3;
  localparam logic [BUS_WIDTH-1:0] NIB_4BIT  = 4'h2;

  localparam logic [DATA_W-1:0] CMD_CLEAR = 8'h01;

  // Instruction bit positions
  localparam int unsigned BIT_DL = 4;
  localparam int unsigned BIT_N  = 3;
  localparam int unsigned BIT_SC = 3;
  localparam int unsigned BIT_RL = 2;
  localparam int unsigned BIT_D  = 2;
  localparam int unsigned BIT_C  = 1;
  localparam int unsigned BIT_B  = 0;
  localparam int unsigned BIT_ID = 1;

  // DDRAM line boundaries
  localparam logic [ADDR_W-1:0] LINE0_START  = 7'h00;
  localparam logic [ADDR_W-1:0] LINE1_START  = 7'h40;
  localparam logic [ADDR_W-1:0] LINE0_END_2L = 7'h27;
  localparam logic [ADDR_W-1:0] LINE1_END_2L = 7'h67;
  localparam logic [ADDR_W-1:0] LINE_END_1L  = 7'h4F;

  typedef enum logic [1:0] {
    ST_BOOT8 = 2'd0,
    ST_HI    = 2'd1,
    ST_LO    = 2'd2,
    ST_CLEAR = 2'd3
  } state_t;

  typedef struct packed {
    logic              rs;
    logic [DATA_W-1:0] data;
  } lcd_cmd_t;

  // Step the address counter, jumping across the gaps between display lines
  function automatic logic [ADDR_W-1:0] ac_step(input logic [ADDR_W-1:0] ac,
                                                input logic inc,
                                                input logic two_line);
    logic [ADDR_W-1:0] nxt;
    nxt = inc ? ac + ADDR_W'(1) : ac - ADDR_W'(1);
    if (two_line) begin
      if (inc && ac == LINE0_END_2L)       nxt = LINE1_START;
      else if (inc && ac == LINE1_END_2L)  nxt = LINE0_START;
      else if (!inc && ac == LINE1_START)  nxt = LINE0_END_2L;
      else if (!inc && ac == LINE0_START)  nxt = LINE1_END_2L;
    end else begin
      if (inc && ac == LINE_END_1L)        nxt = LINE0_START;
      else if (!inc && ac == LINE0_START)  nxt = LINE_END_1L;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/hd44780_ddram.sv
// 128x8 DDRAM image: one write port, one registered read port (read-before-write).
// Ports: clk, rst (async active low, clears only the read register),
//        we/waddr/wdata write port, raddr/rdata read port.
module hd44780_ddram
  import hd44780_lcd_model_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Array content is deliberately not reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register sees the pre-write contents on a same-address write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rdata <= '0;
    else      rdata <= mem[raddr];
  end

endmodule

// File: rtl/hd44780_lcd_model.sv
// Display-side responder for the 4-bit HD44780 bus. Samples e/rs/db, rebuilds
// bytes from nibbles, executes instructions and keeps a DDRAM image.
// Ports: clk, rst (async active low); e/rs/db bus inputs; rd_addr/rd_data
//        DDRAM peek (1-cycle latency); cmd_valid/cmd_rs/cmd_byte executed byte;
//        ac, four_bit, two_line, disp_on, cursor_on, blink_on, busy, err state.
module hd44780_lcd_model
  import hd44780_lcd_model_pkg::*;
#(
  parameter logic [DATA_W-1:0] CLEAR_CHAR   = 8'h20,
  parameter int unsigned       CLEAR_CYCLES = 128
)(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 e,
  input  logic                 rs,
  input  logic [BUS_WIDTH-1:0] db,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [DATA_W-1:0]    rd_data,
  output logic                 cmd_valid,
  output logic                 cmd_rs,
  output logic [DATA_W-1:0]    cmd_byte,
  output logic [ADDR_W-1:0]    ac,
  output logic                 four_bit,
  output logic                 two_line,
  output logic                 disp_on,
  output logic                 cursor_on,
  output logic                 blink_on,
  output logic                 busy,
  output logic                 err
);

  localparam int unsigned       CNT_W     = $clog2(CLEAR_CYCLES);
  localparam logic [CNT_W-1:0]  FILL_LAST = CNT_W'(CLEAR_CYCLES - 1);

  state_t                 state, state_d;
  logic                   e_q, rs_q;
  logic [BUS_WIDTH-1:0]   db_q, hi_nib, hi_nib_d;
  logic                   hi_rs, hi_rs_d;
  logic                   id_q, id_d, cgram_q, cgram_d;
  logic [CNT_W-1:0]       fill_cnt, fill_cnt_d;
  logic [ADDR_W-1:0]      ac_d;
  logic                   four_bit_d, two_line_d, disp_on_d, cursor_on_d, blink_on_d;
  logic                   busy_d, err_d, cmd_valid_d;
  lcd_cmd_t               cmd_d, exec;
  logic                   strobe, is_clear_cmd;
  logic                   we;
  logic [ADDR_W-1:0]      waddr;
  logic [DATA_W-1:0]      wdata;

  // Falling edge of e; rs_q/db_q still hold the last high-cycle values
  assign strobe       = e_q & ~e;
  assign exec         = '{rs: rs_q, data: {hi_nib, db_q}};
  assign is_clear_cmd = strobe && (state == ST_LO) && !rs_q && (exec.data == CMD_CLEAR);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_BOOT8;
      e_q       <= 1'b0;
      rs_q      <= 1'b0;
      db_q      <= '0;
      hi_nib    <= '0;
      hi_rs     <= 1'b0;
      id_q      <= 1'b1;
      cgram_q   <= 1'b0;
      fill_cnt  <= '0;
      ac        <= '0;
      four_bit  <= 1'b0;
      two_line  <= 1'b0;
      disp_on   <= 1'b0;
      cursor_on <= 1'b0;
      blink_on  <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_rs    <= 1'b0;
      cmd_byte  <= '0;
    end else begin
      state     <= state_d;
      e_q       <= e;
      rs_q      <= rs;
      db_q      <= db;
      hi_nib    <= hi_nib_d;
      hi_rs     <= hi_rs_d;
      id_q      <= id_d;
      cgram_q   <= cgram_d;
      fill_cnt  <= fill_cnt_d;
      ac        <= ac_d;
      four_bit  <= four_bit_d;
      two_line  <= two_line_d;
      disp_on   <= disp_on_d;
      cursor_on <= cursor_on_d;
      blink_on  <= blink_on_d;
      busy      <= busy_d;
      err       <= err_d;
      cmd_valid <= cmd_valid_d;
      cmd_rs    <= cmd_d.rs;
      cmd_byte  <= cmd_d.data;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      ST_BOOT8: if (strobe && !rs_q && db_q == NIB_4BIT) state_d = ST_HI;
      ST_HI:    if (strobe) state_d = ST_LO;
      ST_LO:    if (strobe) state_d = is_clear_cmd ? ST_CLEAR : ST_HI;
      ST_CLEAR: if (fill_cnt == FILL_LAST) state_d = ST_HI;
      default:  state_d = ST_BOOT8;
    endcase
  end

  // Datapath / output next values, instruction decode and DDRAM write port
  always_comb begin
    hi_nib_d    = hi_nib;
    hi_rs_d     = hi_rs;
    id_d        = id_q;
    cgram_d     = cgram_q;
    fill_cnt_d  = fill_cnt;
    ac_d        = ac;
    four_bit_d  = four_bit;
    two_line_d  = two_line;
    disp_on_d   = disp_on;
    cursor_on_d = cursor_on;
    blink_on_d  = blink_on;
    err_d       = err;
    cmd_valid_d = 1'b0;
    cmd_d       = '{rs: cmd_rs, data: cmd_byte};
    busy_d      = (state_d == ST_CLEAR);
    we          = 1'b0;
    waddr       = ac;
    wdata       = exec.data;

    case (state)
      ST_BOOT8: begin
        if (strobe) begin
          cmd_valid_d = 1'b1;
          cmd_d       = '{rs: rs_q, data: {db_q, 4'h0}};
          if (!rs_q && db_q == NIB_4BIT)       four_bit_d = 1'b1;
          else if (rs_q || db_q != NIB_BOOT8)  err_d      = 1'b1;
        end
      end
      ST_HI: begin
        if (strobe) begin
          hi_nib_d = db_q;
          hi_rs_d  = rs_q;
        end
      end
      ST_LO: begin
        if (strobe) begin
          cmd_valid_d = 1'b1;
          cmd_d       = exec;
          if (hi_rs != rs_q) err_d = 1'b1;
          if (rs_q) begin
            if (!cgram_q) begin
              we   = 1'b1;
              ac_d = ac_step(ac, id_q, two_line);
            end
          end else if (exec.data[7]) begin
            ac_d    = exec.data[6:0];
            cgram_d = 1'b0;
          end else if (exec.data[6]) begin
            cgram_d = 1'b1;
          end else if (exec.data[5]) begin
            two_line_d = exec.data[BIT_N];
            if (exec.data[BIT_DL]) err_d = 1'b1;
          end else if (exec.data[4]) begin
            if (!exec.data[BIT_SC]) ac_d = ac_step(ac, exec.data[BIT_RL], two_line);
          end else if (exec.data[3]) begin
            disp_on_d   = exec.data[BIT_D];
            cursor_on_d = exec.data[BIT_C];
            blink_on_d  = exec.data[BIT_B];
          end else if (exec.data[2]) begin
            id_d = exec.data[BIT_ID];
          end else if (exec.data[1]) begin
            ac_d = '0;
          end else if (exec.data[0]) begin
            fill_cnt_d = '0;
          end
        end
      end
      ST_CLEAR: begin
        // Fill one location per cycle; extra cycles beyond 128 rewrite the same char
        we         = 1'b1;
        waddr      = ADDR_W'(fill_cnt);
        wdata      = CLEAR_CHAR;
        fill_cnt_d = fill_cnt + CNT_W'(1);
        if (strobe) err_d = 1'b1;
        if (fill_cnt == FILL_LAST) begin
          fill_cnt_d = '0;
          ac_d       = '0;
          id_d       = 1'b1;
        end
      end
      default: ;
    endcase
  end

  hd44780_ddram u_ddram (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

endmodule
